encoder_83_arb: RTL and testbench
=================================

// Module: encoder_83_arb
// PURPOSE
//   Registered 8-to-3 priority encoder with request capture and a valid/ready output.
//   It is the encoding counterpart of the team's 3-8 decoder, using 74x148-style active-low
//   request inputs. Falling edges on req_n are latched as pending requests. The highest pending
//   index is presented as a 3-bit code and cleared when the consumer accepts it.
//   Sits between asynchronous request sources (buttons, IRQ lines) and a single service FSM.
// PARAMETERS
//   N   8              number of request lines; bit N-1 has highest priority
//   W   $clog2(N) = 3  code width; derived, not overridden
// PORTS
//   clk    in   1  single clock; all state updates on posedge
//   rst_n  in   1  asynchronous active-low reset
//   EI_n   in   1  enable, active-low; 1 = freeze capture and new loads
//   req_n  in   N  request lines, active-low; a falling edge raises a request
//   ready  in   1  consumer accepts code when valid & ready at posedge
//   code   out  W  index of the presented request, binary
//   valid  out  1  code is valid; held until accepted
//   ovf    out  1  one-cycle pulse: edge arrived on an already-pending, non-accepted line
//   EO_n   out  1  low when EI_n=0, nothing pending and valid=0 (idle, cascadable)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - s1 = s2 = all 1; pend = 0; code = 0; valid = 0; ovf = 0.
//     - EO_n follows its combinational rule: 0 if EI_n=0, else 1.
//   Input capture:
//     - Two-flop sampler: s1 <= req_n, s2 <= s1.
//     - fall[i] = s2[i] & ~s1[i], gated by EI_n=0.
//     - With EI_n=1, edges are discarded, not deferred.
//   Pending register, per bit, on each posedge:
//     - acc = valid & ready; clr[i] = acc & (code==i).
//     - pend[i] <= fall[i] | (pend[i] & ~clr[i]). Set wins over clear on the same bit.
//     - ovf <= |(fall & pend & ~clr); otherwise ovf <= 0.
//   Output register:
//     - Candidates: cand = pend & ~clr & ~pres, where pres = onehot(code) when valid.
//     - Same-cycle fall bits are not candidates.
//     - load = EI_n==0 & (!valid | acc) & |cand.
//     - On load: code <= index of highest set bit in cand; valid <= 1.
//     - Else if acc: valid <= 0, code holds its last value.
//     - Else: hold.
//     - No preemption: code is stable while valid & !ready, even if a higher request arrives.
//     - EI_n=1 does not drop a presented code; it stays valid until accepted.
//   Latency and throughput:
//     - Let k be the first posedge sampling req_n[i]=0. Then s1 updates at k, pend[i] sets at
//       k+1, and code/valid appear at k+2 if idle.
//     - With ready=1, one code is accepted per cycle back-to-back.
//     - A presented bit stays pending until accepted; pres keeps it from being re-selected.
//   Boundaries:
//     - A line held low produces one request only; it must rise and fall again to re-request.
//     - A line held low through reset is captured once after reset, because s1/s2 reset high.
//     - A new edge on the presented line during acceptance re-arms that bit (set wins).
//     - A new edge on the presented line while it is not accepted pulses ovf. Only one service.
//     - Reset mid-operation discards all pending requests and any presented code immediately.
// STRUCTURE
//   - Package enc_pkg: localparam N_DEF=8; function clog2.
//   - Sub-module prio_enc_n (combinational, parameter N):
//     in vec[N-1:0]; out idx[W-1:0], hit; MSB has highest priority.
//   - Top: sampler, pend register, output register and control, all in clk/rst_n.
// TESTING
//   1 Reset with EI_n=0, req_n=8'hFF -> code=0, valid=0, ovf=0, EO_n=0; values hold after release.
//   2 req_n[5] falls, ready=1 -> valid=1, code=5 two cycles after the first sampling edge;
//     valid=0 the next cycle; EO_n back to 0.
//   3 req_n[2] and req_n[6] fall together, ready=1 -> code 6 then code 2 on consecutive cycles;
//     then valid=0.
//   4 code=3 presented, ready=0; bit 7 falls -> code stays 3 for 4 cycles;
//     ready=1 -> next cycle code=7.
//   5 Bit 1 pending, not yet presented (code=4 held); bit 1 toggles high then low ->
//     ovf=1 for exactly 1 cycle; code 1 is delivered only once.
//   6 EI_n=1 while bit 0 falls -> no capture, valid stays 0, EO_n=1.
//     Pending bits 3 and 4, then rst_n pulsed low -> valid=0, pend=0, no codes delivered
//     after release.

Source files
------------

// File: rtl/encoder_83_arb_pkg.sv
// Shared constants and helpers for the 8-to-3 request encoder.
package enc_pkg;
  localparam int N_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/encoder_83_arb_if.sv
// Request/handshake bundle between request sources, the encoder and its consumer.
interface encoder_83_arb_if #(
  parameter int N = enc_pkg::N_DEF
) ();
  localparam int W = enc_pkg::clog2(N);

  logic         EI_n;
  logic [N-1:0] req_n;
  logic         ready;
  logic [W-1:0] code;
  logic         valid;
  logic         ovf;
  logic         EO_n;

  modport slave  (input EI_n, req_n, ready, output code, valid, ovf, EO_n);
  modport master (output EI_n, req_n, ready, input code, valid, ovf, EO_n);
endinterface

// File: rtl/encoder_83_arb_prio_enc_n.sv
// Combinational N-input priority encoder; the highest set bit wins.
module prio_enc_n #(
  parameter int N = enc_pkg::N_DEF,
  localparam int W = enc_pkg::clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         hit
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (vec[i]) idx = W'(i);
  end

  assign hit = |vec;
endmodule

// File: rtl/encoder_83_arb.sv
// Registered priority encoder: captures falling edges on active-low request lines and
// presents the highest pending index on a valid/ready output, one code per acceptance.
module encoder_83_arb
  import enc_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  encoder_83_arb_if.slave   bus
);
  localparam int W = clog2(N);

  logic [N-1:0] s1_q, s2_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] fall, pres, clr, cand;
  logic [W-1:0] code_q, code_d, sel_idx;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;
  logic         acc, load, hit;
  logic         en;

  assign en   = ~bus.EI_n;
  assign acc  = valid_q & bus.ready;
  // The presented bit is still pending; masking it avoids handing the same code out twice.
  assign pres = valid_q ? ({{(N-1){1'b0}}, 1'b1} << code_q) : '0;
  assign clr  = acc ? pres : '0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign fall[i]   = en & s2_q[i] & ~s1_q[i];
    assign pend_d[i] = fall[i] | (pend_q[i] & ~clr[i]);
    assign cand[i]   = pend_q[i] & ~clr[i] & ~pres[i];
  end

  assign ovf_d = |(fall & pend_q & ~clr);

  prio_enc_n #(.N(N)) u_prio (
    .vec (cand),
    .idx (sel_idx),
    .hit (hit)
  );

  assign load = en & (~valid_q | acc) & hit;

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    if (load) begin
      code_d  = sel_idx;
      valid_d = 1'b1;
    end else if (acc) begin
      valid_d = 1'b0;
    end
  end

  // Samplers reset high so a line held low through reset still yields one edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '1;
      s2_q    <= '1;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= bus.req_n;
      s2_q    <= s1_q;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.EO_n  = bus.EI_n | (|pend_q) | valid_q;
endmodule

// File: tb/tb_encoder_83_arb.sv
// Directed and randomized checks of encoder_83_arb against a per-cycle behavioural model.
module tb_encoder_83_arb;
  logic clk;
  logic rst_n;

  encoder_83_arb_if #(.N(8)) bus ();

  encoder_83_arb #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: sampled history, pending set, presented index (-1 = nothing presented)
  bit m_s1 [8];
  bit m_s2 [8];
  bit m_pend [8];
  int m_pres;
  int m_code;
  bit m_ovf;
  int q_model [$];
  int q_dut [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_s1[i] = 1'b1;
      m_s2[i] = 1'b1;
      m_pend[i] = 1'b0;
    end
    m_pres = -1;
    m_code = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic m_step();
    bit f [8];
    bit np [8];
    bit accepted;
    bit any_ovf;
    int best;
    accepted = (m_pres >= 0) && bus.ready;
    if (accepted) q_model.push_back(m_pres);
    any_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i] = !bus.EI_n && m_s2[i] && !m_s1[i];
      if (f[i] && m_pend[i] && !(accepted && i == m_pres)) any_ovf = 1'b1;
      np[i] = f[i] || (m_pend[i] && !(accepted && i == m_pres));
    end
    best = -1;
    if (!bus.EI_n && (m_pres < 0 || accepted))
      for (int i = 7; i >= 0; i--)
        if (best < 0 && m_pend[i] && i != m_pres) best = i;
    if (best >= 0) begin
      m_pres = best;
      m_code = best;
    end else if (accepted) begin
      m_pres = -1;
    end
    m_ovf = any_ovf;
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = np[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = bus.req_n[i];
    end
  endtask

  task automatic chk_all();
    bit idle;
    idle = !bus.EI_n && (m_pres < 0);
    for (int i = 0; i < 8; i++) if (m_pend[i]) idle = 1'b0;
    chk("code",  bus.code,  m_code);
    chk("valid", bus.valid, m_pres >= 0);
    chk("ovf",   bus.ovf,   m_ovf);
    chk("EO_n",  bus.EO_n,  !idle);
  endtask

  task automatic cyc();
    logic       pa;
    logic [2:0] pc;
    @(negedge clk);
    pa = rst_n && bus.valid && bus.ready;
    pc = bus.code;
    @(posedge clk);
    if (pa) q_dut.push_back(int'(pc));
    if (!rst_n) m_reset();
    else m_step();
    #1;
    chk_all();
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_all();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  function automatic int count_from(input int start, input int val);
    int c;
    c = 0;
    for (int i = start; i < q_dut.size(); i++) if (q_dut[i] == val) c++;
    return c;
  endfunction

  initial begin
    int oc;
    int st;
    int n;
    logic [7:0] r;

    // 1: reset state
    bus.EI_n  = 1'b0;
    bus.req_n = 8'hFF;
    bus.ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    m_reset();
    chk("t1_code", bus.code, 0);
    chk("t1_valid", bus.valid, 0);
    chk("t1_ovf", bus.ovf, 0);
    chk("t1_EO_n", bus.EO_n, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("t1_hold_valid", bus.valid, 0);
    chk("t1_hold_code", bus.code, 0);

    // 2: single request, code two cycles after the first sampling edge
    bus.ready = 1'b1;
    bus.req_n = 8'hDF;
    repeat (2) cyc();
    chk("t2_early_valid", bus.valid, 0);
    cyc();
    chk("t2_valid", bus.valid, 1);
    chk("t2_code", bus.code, 5);
    cyc();
    chk("t2_drop", bus.valid, 0);
    chk("t2_EO_n", bus.EO_n, 0);
    bus.req_n = 8'hFF;
    repeat (3) cyc();

    // 3: simultaneous requests drain in priority order
    bus.req_n = 8'hBB;
    repeat (3) cyc();
    chk("t3_code6", bus.code, 6);
    chk("t3_valid6", bus.valid, 1);
    cyc();
    chk("t3_code2", bus.code, 2);
    chk("t3_valid2", bus.valid, 1);
    cyc();
    chk("t3_empty", bus.valid, 0);
    bus.req_n = 8'hFF;
    repeat (3) cyc();

    // 4: no preemption while stalled
    bus.ready = 1'b0;
    bus.req_n = 8'hF7;
    repeat (3) cyc();
    chk("t4_code3", bus.code, 3);
    bus.req_n = 8'h77;
    repeat (4) begin
      cyc();
      chk("t4_stall", bus.code, 3);
    end
    bus.ready = 1'b1;
    cyc();
    chk("t4_code7", bus.code, 7);
    chk("t4_valid7", bus.valid, 1);
    cyc();
    chk("t4_empty", bus.valid, 0);
    bus.req_n = 8'hFF;
    repeat (3) cyc();

    // 5: re-edge on a pending, not-presented line pulses ovf once; single delivery
    bus.ready = 1'b0;
    bus.req_n = 8'hED;
    repeat (3) cyc();
    chk("t5_code4", bus.code, 4);
    bus.req_n = 8'hEF;
    repeat (2) cyc();
    bus.req_n = 8'hED;
    oc = 0;
    repeat (5) begin
      cyc();
      if (bus.ovf) oc++;
    end
    chk("t5_ovf_cnt", oc, 1);
    st = q_dut.size();
    bus.ready = 1'b1;
    repeat (5) cyc();
    chk("t5_one_deliv", count_from(st, 1), 1);
    chk("t5_deliv4", count_from(st, 4), 1);
    bus.req_n = 8'hFF;
    repeat (3) cyc();

    // 6: disabled capture, then reset discards pending work
    bus.ready = 1'b0;
    bus.EI_n  = 1'b1;
    bus.req_n = 8'hFE;
    repeat (4) cyc();
    chk("t6_dis_valid", bus.valid, 0);
    chk("t6_dis_EO_n", bus.EO_n, 1);
    bus.EI_n = 1'b0;
    repeat (4) cyc();
    chk("t6_no_defer", bus.valid, 0);
    bus.req_n = 8'hE7;
    repeat (2) cyc();
    chk("t6_pend_EO_n", bus.EO_n, 1);
    bus.req_n = 8'hFF;
    st = q_dut.size();
    rst_pulse();
    bus.ready = 1'b1;
    repeat (6) cyc();
    chk("t6_rst_valid", bus.valid, 0);
    chk("t6_rst_EO_n", bus.EO_n, 0);
    chk("t6_no_deliv", q_dut.size() - st, 0);

    // line held low through reset is captured exactly once
    bus.req_n = 8'hBF;
    rst_pulse();
    st = q_dut.size();
    repeat (8) cyc();
    chk("held_cnt", q_dut.size() - st, 1);
    chk("held_code6", count_from(st, 6), 1);
    bus.req_n = 8'hFF;
    repeat (3) cyc();

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      r = bus.req_n;
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      bus.req_n = r;
      bus.ready = ($urandom_range(0, 2) != 0);
      bus.EI_n  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 149) == 0) rst_pulse();
      else cyc();
    end

    chk("n_deliv", q_dut.size(), q_model.size());
    n = (q_dut.size() < q_model.size()) ? q_dut.size() : q_model.size();
    for (int i = 0; i < n; i++) chk("deliv", q_dut[i], q_model[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
